// File: rtl/neuraedge_ni_rx.sv
// rtl/neuraedge_ni_rx.sv - NoC network-interface receive stage: depacketizes flits into PE row-buffer writes.
// Optional header parity check enabled by defining NE_NI_PARITY_EN.
`timescale 1ns/1ps
module neuraedge_ni_rx #(
  parameter int PE_ROWS    = 32,
  parameter int PE_COLS    = 64,
  parameter int NOC_FLIT_W = 64,
  localparam int WORDS     = PE_COLS / 4,
  localparam int ROW_W     = $clog2(PE_ROWS),
  localparam int ADDR_W    = $clog2(WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NOC_FLIT_W-1:0] flit_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ROW_W-1:0]      wr_row,
  output logic                  wr_chan,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [NOC_FLIT_W-1:0] wr_data,
  output logic                  pkt_done,
  output logic                  err,
  output logic [1:0]            err_code
);

  localparam logic [8:0] WORDS_L   = 9'(WORDS);
  localparam logic [8:0] ROWS_L    = 9'(PE_ROWS);
  localparam logic [1:0] TYPE_HEAD = 2'b01;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic                  chan_q, chan_d;
  logic                  wr_valid_q, wr_valid_d;
  logic [ROW_W-1:0]      wr_row_q, wr_row_d;
  logic                  wr_chan_q, wr_chan_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic [NOC_FLIT_W-1:0] wr_data_q, wr_data_d;
  logic [1:0]            err_code_q, err_code_d;

  logic       ready_c, accept, err_c, pkt_done_c, parity_bad, len_zero, len_row_bad;
  logic [1:0] code_c;
  logic [7:0] hdr_len;
  logic [7:0] hdr_row;

  assign hdr_len     = flit_in[55:48];
  assign hdr_row     = flit_in[47:40];
  assign len_zero    = (hdr_len == 8'd0);
  assign len_row_bad = ({1'b0, hdr_len} > WORDS_L) || ({1'b0, hdr_row} >= ROWS_L);

`ifdef NE_NI_PARITY_EN
  assign parity_bad = (^flit_in[63:1]) != flit_in[0];
`else
  assign parity_bad = 1'b0;
`endif

  // LOAD can accept whenever the output register is free or draining this cycle.
  assign ready_c = !rst && ((state_q != S_LOAD) || !wr_valid_q || wr_ready);
  assign accept  = valid_in && ready_c;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    row_d      = row_q;
    chan_d     = chan_q;
    wr_valid_d = wr_valid_q && !wr_ready;
    wr_row_d   = wr_row_q;
    wr_chan_d  = wr_chan_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    err_c      = 1'b0;
    code_c     = err_code_q;
    pkt_done_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (flit_in[63:62] != TYPE_HEAD) begin
            err_c  = 1'b1;
            code_c = 2'd1;
          end else if (parity_bad) begin
            err_c  = 1'b1;
            code_c = 2'd3;
            if (!len_zero) begin
              cnt_d   = hdr_len;
              state_d = S_DRAIN;
            end
          end else if (len_zero) begin
            err_c  = 1'b1;
            code_c = 2'd2;
          end else if (len_row_bad) begin
            err_c   = 1'b1;
            code_c  = 2'd2;
            cnt_d   = hdr_len;
            state_d = S_DRAIN;
          end else begin
            row_d   = hdr_row[ROW_W-1:0];
            chan_d  = flit_in[32];
            cnt_d   = hdr_len;
            addr_d  = '0;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          wr_valid_d = 1'b1;
          wr_data_d  = flit_in;
          wr_addr_d  = addr_q;
          wr_row_d   = row_q;
          wr_chan_d  = chan_q;
          addr_d     = addr_q + 1'b1;
          cnt_d      = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            pkt_done_c = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        if (accept) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    err_code_d = code_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      row_q      <= '0;
      chan_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_row_q   <= '0;
      wr_chan_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      err_code_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      row_q      <= row_d;
      chan_q     <= chan_d;
      wr_valid_q <= wr_valid_d;
      wr_row_q   <= wr_row_d;
      wr_chan_q  <= wr_chan_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      err_code_q <= err_code_d;
    end
  end

  assign ready_out = ready_c;
  assign wr_valid  = wr_valid_q;
  assign wr_row    = wr_row_q;
  assign wr_chan   = wr_chan_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign pkt_done  = pkt_done_c;
  assign err       = err_c;
  assign err_code  = code_c;

endmodule

// File: tb/tb_neuraedge_ni_rx.sv
// tb/tb_neuraedge_ni_rx.sv - self-checking bench for neuraedge_ni_rx against a packet-level model.
`timescale 1ns/1ps
module tb_neuraedge_ni_rx;

  typedef struct packed {
    logic [4:0]  row;
    logic        chan;
    logic [3:0]  addr;
    logic [63:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] flit_in = '0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic        wr_valid;
  logic        wr_ready = 1'b1;
  logic [4:0]  wr_row;
  logic        wr_chan;
  logic [3:0]  wr_addr;
  logic [63:0] wr_data;
  logic        pkt_done;
  logic        err;
  logic [1:0]  err_code;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int first_wcyc = -1;
  int last_wcyc  = -1;
  bit bp_rand  = 1'b0;

  wr_t        exp_w[$], obs_w[$];
  logic [1:0] exp_e[$], obs_e[$];
  int         exp_pd = 0, obs_pd = 0;

  neuraedge_ni_rx dut (
    .clk(clk), .rst(rst), .flit_in(flit_in), .valid_in(valid_in), .ready_out(ready_out),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row), .wr_chan(wr_chan),
    .wr_addr(wr_addr), .wr_data(wr_data), .pkt_done(pkt_done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (wr_valid && wr_ready) begin
        obs_w.push_back({wr_row, wr_chan, wr_addr, wr_data});
        if (first_wcyc < 0) first_wcyc = cyc;
        last_wcyc = cyc;
      end
      if (err) obs_e.push_back(err_code);
      if (pkt_done) obs_pd++;
    end
  end

  function automatic logic [63:0] mk_hdr(logic [1:0] typ, logic [7:0] len, logic [7:0] row,
                                         logic chan, logic flip);
    logic [63:0] h;
    h = {$urandom, $urandom};
    h[63:62] = typ;
    h[55:48] = len;
    h[47:40] = row;
    h[32]    = chan;
    h[0]     = (^h[63:1]) ^ flip;
    return h;
  endfunction

  task automatic clear_obs();
    exp_w.delete(); obs_w.delete(); exp_e.delete(); obs_e.delete();
    exp_pd = 0; obs_pd = 0; first_wcyc = -1; last_wcyc = -1;
  endtask

  task automatic send_flit(input logic [63:0] f);
    int n = 0;
    flit_in  = f;
    valid_in = 1'b1;
    forever begin
      if (bp_rand) wr_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (ready_out) break;
      n++;
      if (n > 200) begin
        n_checks++;
        $display("FAIL send_timeout: ready_out stuck low, required high");
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic flush();
    bp_rand  = 1'b0;
    valid_in = 1'b0;
    wr_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Packet-level model: classify the header by the protocol rules, then send it with npl payloads.
  task automatic run_pkt(input logic [63:0] h, input int npl);
    logic [1:0]  code;
    logic [63:0] d;
    code = 2'd0;
    if (h[63:62] != 2'b01) code = 2'd1;
`ifdef NE_NI_PARITY_EN
    else if (^h != 1'b0) code = 2'd3;
`endif
    else if (h[55:48] == 0 || h[55:48] > 16 || h[47:40] >= 32) code = 2'd2;
    if (code != 0) exp_e.push_back(code);
    else exp_pd++;
    send_flit(h);
    for (int i = 0; i < npl; i++) begin
      d = {$urandom, $urandom};
      if (code == 0) exp_w.push_back({h[44:40], h[32], 4'(i), d});
      send_flit(d);
    end
  endtask

  task automatic test_reset();
    wr_ready = 1'b1;
    flit_in  = mk_hdr(2'b01, 8'd1, 8'd1, 1'b0, 1'b0);
    valid_in = 1'b1;
    #2 rst = 1'b1;
    @(negedge clk);
    n_checks++; if (ready_out !== 1'b0) $display("FAIL rst_ready: got %b exp 0", ready_out); else n_pass++;
    n_checks++; if (wr_valid !== 1'b0) $display("FAIL rst_wr_valid: got %b exp 0", wr_valid); else n_pass++;
    n_checks++;
    if ({wr_row, wr_chan, wr_addr, wr_data} !== '0)
      $display("FAIL rst_wr_fields: got %h exp 0", {wr_row, wr_chan, wr_addr, wr_data});
    else n_pass++;
    n_checks++;
    if ({pkt_done, err, err_code} !== 4'b0)
      $display("FAIL rst_flags: got %b exp 0000", {pkt_done, err, err_code});
    else n_pass++;
    valid_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_good_packet();
    clear_obs();
    run_pkt(mk_hdr(2'b01, 8'd16, 8'd5, 1'b1, 1'b0), 16);
    flush();
    n_checks++; if (obs_w.size() != exp_w.size()) $display("FAIL good_wcount: got %0d exp %0d", obs_w.size(), exp_w.size()); else n_pass++;
    for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
      n_checks++; if (obs_w[i] !== exp_w[i]) $display("FAIL good_write[%0d]: got %h exp %h", i, obs_w[i], exp_w[i]); else n_pass++;
    end
    n_checks++; if (last_wcyc - first_wcyc != 15) $display("FAIL good_span: got %0d exp 15", last_wcyc - first_wcyc); else n_pass++;
    n_checks++; if (obs_pd != 1) $display("FAIL good_pkt_done: got %0d exp 1", obs_pd); else n_pass++;
    n_checks++; if (obs_e.size() != 0) $display("FAIL good_err: got %0d exp 0", obs_e.size()); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [63:0] d[4];
    clear_obs();
    for (int i = 0; i < 4; i++) begin
      d[i] = {$urandom, $urandom};
      exp_w.push_back({5'd3, 1'b0, 4'(i), d[i]});
    end
    wr_ready = 1'b1;
    send_flit(mk_hdr(2'b01, 8'd4, 8'd3, 1'b0, 1'b0));
    send_flit(d[0]);
    wr_ready = 1'b0;
    flit_in  = d[1];
    valid_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++; if (ready_out !== 1'b0) $display("FAIL bp_ready[%0d]: got %b exp 0", k, ready_out); else n_pass++;
      n_checks++; if (wr_data !== d[0]) $display("FAIL bp_hold[%0d]: got %h exp %h", k, wr_data, d[0]); else n_pass++;
      @(posedge clk); #1;
    end
    wr_ready = 1'b1;
    for (int i = 1; i < 4; i++) send_flit(d[i]);
    flush();
    n_checks++; if (obs_w.size() != 4) $display("FAIL bp_wcount: got %0d exp 4", obs_w.size()); else n_pass++;
    for (int i = 0; i < obs_w.size() && i < 4; i++) begin
      n_checks++; if (obs_w[i] !== exp_w[i]) $display("FAIL bp_write[%0d]: got %h exp %h", i, obs_w[i], exp_w[i]); else n_pass++;
    end
    n_checks++; if (obs_pd != 1) $display("FAIL bp_pkt_done: got %0d exp 1", obs_pd); else n_pass++;
  endtask

  task automatic test_bad_row();
    clear_obs();
    run_pkt(mk_hdr(2'b01, 8'd3, 8'd40, 1'b0, 1'b0), 3);
    run_pkt(mk_hdr(2'b01, 8'd17, 8'd0, 1'b1, 1'b0), 17);
    run_pkt(mk_hdr(2'b01, 8'd8, 8'd7, 1'b0, 1'b0), 8);
    run_pkt(mk_hdr(2'b01, 8'd16, 8'd31, 1'b1, 1'b0), 16);
    flush();
    n_checks++; if (obs_w.size() != exp_w.size()) $display("FAIL badrow_wcount: got %0d exp %0d", obs_w.size(), exp_w.size()); else n_pass++;
    for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
      n_checks++; if (obs_w[i] !== exp_w[i]) $display("FAIL badrow_write[%0d]: got %h exp %h", i, obs_w[i], exp_w[i]); else n_pass++;
    end
    n_checks++; if (obs_e.size() != exp_e.size()) $display("FAIL badrow_ecount: got %0d exp %0d", obs_e.size(), exp_e.size()); else n_pass++;
    for (int i = 0; i < obs_e.size() && i < exp_e.size(); i++) begin
      n_checks++; if (obs_e[i] !== exp_e[i]) $display("FAIL badrow_code[%0d]: got %0d exp %0d", i, obs_e[i], exp_e[i]); else n_pass++;
    end
    n_checks++; if (obs_pd != exp_pd) $display("FAIL badrow_pkt_done: got %0d exp %0d", obs_pd, exp_pd); else n_pass++;
  endtask

  task automatic test_bad_type_len0();
    clear_obs();
    run_pkt(mk_hdr(2'b10, 8'd4, 8'd2, 1'b0, 1'b0), 0);
    run_pkt(mk_hdr(2'b01, 8'd0, 8'd2, 1'b1, 1'b0), 0);
    run_pkt(mk_hdr(2'b01, 8'd2, 8'd2, 1'b1, 1'b0), 2);
    flush();
    n_checks++; if (obs_e.size() != 2) $display("FAIL type_ecount: got %0d exp 2", obs_e.size()); else n_pass++;
    for (int i = 0; i < obs_e.size() && i < exp_e.size(); i++) begin
      n_checks++; if (obs_e[i] !== exp_e[i]) $display("FAIL type_code[%0d]: got %0d exp %0d", i, obs_e[i], exp_e[i]); else n_pass++;
    end
    n_checks++; if (obs_w.size() != exp_w.size()) $display("FAIL type_wcount: got %0d exp %0d", obs_w.size(), exp_w.size()); else n_pass++;
    for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
      n_checks++; if (obs_w[i] !== exp_w[i]) $display("FAIL type_write[%0d]: got %h exp %h", i, obs_w[i], exp_w[i]); else n_pass++;
    end
    n_checks++; if (err_code !== 2'd2) $display("FAIL type_code_held: got %0d exp 2", err_code); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [63:0] d;
    clear_obs();
    wr_ready = 1'b1;
    send_flit(mk_hdr(2'b01, 8'd8, 8'd9, 1'b0, 1'b0));
    d = {$urandom, $urandom};
    exp_w.push_back({5'd9, 1'b0, 4'd0, d});
    send_flit(d);
    send_flit({$urandom, $urandom});
    rst = 1'b1;
    #1;
    n_checks++; if (wr_valid !== 1'b0) $display("FAIL mid_wr_valid: got %b exp 0", wr_valid); else n_pass++;
    n_checks++; if (ready_out !== 1'b0) $display("FAIL mid_ready: got %b exp 0", ready_out); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d = {$urandom, $urandom};
      if (d[63:62] == 2'b01) d[63:62] = 2'b11;
      run_pkt(d, 0);
    end
    flush();
    n_checks++; if (obs_w.size() != 1) $display("FAIL mid_wcount: got %0d exp 1", obs_w.size()); else n_pass++;
    if (obs_w.size() > 0) begin
      n_checks++; if (obs_w[0] !== exp_w[0]) $display("FAIL mid_write: got %h exp %h", obs_w[0], exp_w[0]); else n_pass++;
    end
    n_checks++; if (obs_e.size() != 6) $display("FAIL mid_ecount: got %0d exp 6", obs_e.size()); else n_pass++;
    for (int i = 0; i < obs_e.size() && i < exp_e.size(); i++) begin
      n_checks++; if (obs_e[i] !== 2'd1) $display("FAIL mid_code[%0d]: got %0d exp 1", i, obs_e[i]); else n_pass++;
    end
  endtask

  task automatic test_parity();
    clear_obs();
    run_pkt(mk_hdr(2'b01, 8'd2, 8'd6, 1'b0, 1'b1), 2);
    run_pkt(mk_hdr(2'b01, 8'd1, 8'd4, 1'b1, 1'b0), 1);
    flush();
    n_checks++; if (obs_w.size() != exp_w.size()) $display("FAIL par_wcount: got %0d exp %0d", obs_w.size(), exp_w.size()); else n_pass++;
    for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
      n_checks++; if (obs_w[i] !== exp_w[i]) $display("FAIL par_write[%0d]: got %h exp %h", i, obs_w[i], exp_w[i]); else n_pass++;
    end
    n_checks++; if (obs_e.size() != exp_e.size()) $display("FAIL par_ecount: got %0d exp %0d", obs_e.size(), exp_e.size()); else n_pass++;
    for (int i = 0; i < obs_e.size() && i < exp_e.size(); i++) begin
      n_checks++; if (obs_e[i] !== exp_e[i]) $display("FAIL par_code[%0d]: got %0d exp %0d", i, obs_e[i], exp_e[i]); else n_pass++;
    end
    n_checks++; if (obs_pd != exp_pd) $display("FAIL par_pkt_done: got %0d exp %0d", obs_pd, exp_pd); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [1:0] typ;
    logic [7:0] len;
    clear_obs();
    bp_rand = 1'b1;
    for (int p = 0; p < 40; p++) begin
      typ = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
      len = 8'($urandom_range(0, 18));
      run_pkt(mk_hdr(typ, len, 8'($urandom_range(0, 36)), 1'($urandom), 1'($urandom_range(0, 7) == 0)),
              (typ == 2'b01) ? int'(len) : 0);
    end
    flush();
    n_checks++; if (obs_w.size() != exp_w.size()) $display("FAIL b2b_wcount: got %0d exp %0d", obs_w.size(), exp_w.size()); else n_pass++;
    for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
      n_checks++; if (obs_w[i] !== exp_w[i]) $display("FAIL b2b_write[%0d]: got %h exp %h", i, obs_w[i], exp_w[i]); else n_pass++;
    end
    n_checks++; if (obs_e.size() != exp_e.size()) $display("FAIL b2b_ecount: got %0d exp %0d", obs_e.size(), exp_e.size()); else n_pass++;
    for (int i = 0; i < obs_e.size() && i < exp_e.size(); i++) begin
      n_checks++; if (obs_e[i] !== exp_e[i]) $display("FAIL b2b_code[%0d]: got %0d exp %0d", i, obs_e[i], exp_e[i]); else n_pass++;
    end
    n_checks++; if (obs_pd != exp_pd) $display("FAIL b2b_pkt_done: got %0d exp %0d", obs_pd, exp_pd); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_backpressure();
    test_bad_row();
    test_bad_type_len0();
    test_reset_mid();
    test_parity();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/neuraedge_ni_rx.md
# neuraedge_ni_rx

Tile network-interface receive stage, sitting directly downstream of the tile NoC router's local (port 4) output. It accepts packets of 64-bit flits from the router and depacketizes them: a header flit selects the target PE row and operand channel, and the following payload flits become addressed 64-bit row-buffer writes toward the PE array. Malformed packets are dropped and flagged. No flit is ever left unconsumed.

## Interface
- PE_ROWS, 32, number of PE rows, addressable by header row field
- PE_COLS, 64, PE columns per row; row buffer depth WORDS = PE_COLS/4 words of 4×16-bit lanes
- NOC_FLIT_W, 64, flit width; fixed at 64 (field map below depends on it)
- clk  in  1  sole clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- flit_in  in  64  flit from router local output
- valid_in  in  1  flit_in valid
- ready_out  out  1  flit accepted when valid_in && ready_out
- wr_valid  out  1  row-buffer write valid
- wr_ready  in  1  row-buffer write accepted when wr_valid && wr_ready
- wr_row  out  $clog2(PE_ROWS)  target PE row
- wr_chan  out  1  0 = weight buffer, 1 = activation buffer
- wr_addr  out  $clog2(WORDS)  word index within row
- wr_data  out  64  four 16-bit lanes, lane 0 in [15:0]
- pkt_done  out  1  one-cycle pulse, last payload flit of a good packet accepted
- err  out  1  one-cycle pulse on any packet error
- err_code  out  2  cause of latest error, held until next error: 1 bad type, 2 bad length/row, 3 parity

## Operation
- Header flit: [63:62] type (2'b01 = HEAD), [55:48] len (payload flit count), [47:40] row, [32] chan, [0] parity; other bits ignored. Payload flits carry raw data, no type field.
- States: IDLE, LOAD, DRAIN. Counter cnt (8 bits) tracks remaining payload flits; addr counter starts at 0.
- IDLE, flit accepted:
  - type != HEAD → err, code 1, flit discarded, stay IDLE.
  - len == 0 → err, code 2, stay IDLE.
  - len > WORDS or row >= PE_ROWS → err, code 2, cnt = len, go DRAIN.
  - otherwise latch row/chan, cnt = len, addr = 0, go LOAD.
- LOAD: each accepted flit loads output register (wr_data = flit, wr_addr = addr), sets wr_valid, addr++, cnt--. When cnt goes 1→0: pulse pkt_done in that acceptance cycle, go IDLE.
- DRAIN: each accepted flit discarded, cnt--; on 1→0 go IDLE, no pkt_done.
- Output register holds until wr_ready; wr_valid clears on handshake unless refilled the same cycle.
- Header acceptance in IDLE does not depend on wr_ready; a pending write from the previous packet keeps its latched row/chan and completes normally (row/chan travel with the output register).

## Timing
- Reset values: ready_out 0 while rst asserted, wr_valid 0, wr_row/wr_chan/wr_addr/wr_data 0, pkt_done 0, err 0, err_code 0; state IDLE, counters 0.
- ready_out: 1 in IDLE and DRAIN; in LOAD = !wr_valid || wr_ready (combinational from wr_ready, full throughput).
- Latency: payload flit accepted in cycle N → wr_valid with its data in cycle N+1.
- Throughput: one flit per cycle sustained; header costs one cycle per packet.
- Back-to-back packets: header may be accepted in the cycle after the last payload flit.
- Reset mid-packet: all state discarded, including pending write; remaining flits of the packet are then seen in IDLE and reported as code 1 errors.

## Configuration
- NE_NI_PARITY_EN defined: header bit [0] must equal XOR of [63:1] (even parity); on mismatch err, code 3, header treated as row error (DRAIN len flits, or stay IDLE if len == 0). Parity checked before length/row checks.
- Undefined: bit [0] ignored, code 3 never produced.

## Test plan
- Good packet: HEAD row 5 chan 1 len 16, 16 data flits, wr_ready=1 → 16 writes addr 0..15 row 5 chan 1, one per cycle, pkt_done with 16th flit acceptance, no err.
- Backpressure: len 4, wr_ready low 3 cycles after first write → ready_out low while stalled, data/addr order preserved, no loss or duplication.
- Bad row: HEAD row 40 len 3 + 3 flits, then good packet → err code 2, no writes for first packet, second packet written correctly.
- Bad type / len 0: payload-type flit in IDLE → err code 1; HEAD len 0 → err code 2, stays IDLE, next header accepted.
- Reset mid-packet: assert rst after 2 of 8 payload flits → wr_valid 0 at once, remaining 6 flits each give err code 1.
- NE_NI_PARITY_EN: header with flipped parity len 2 → err code 3, 2 flits drained, no writes; without macro same header loads normally.
